// File: rtl/asym_dpram_ctl_if.sv
// Bus bundle for the asymmetric dual-port RAM controller: narrow write port,
// wide read port and the clear-engine handshake.
interface asym_dpram_ctl_if #(
    parameter int unsigned WR_WIDTH = 8,
    parameter int unsigned RATIO    = 2,
    parameter int unsigned RD_DEPTH = 2048
);
    localparam int unsigned RW = WR_WIDTH * RATIO;
    localparam int unsigned AW = $clog2(RD_DEPTH * RATIO);
    localparam int unsigned RA = $clog2(RD_DEPTH);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [WR_WIDTH-1:0] wr_data;
    logic                rd_en;
    logic [RA-1:0]       rd_addr;
    logic [RW-1:0]       rd_data;
    logic                rd_valid;
    logic                clear_req;
    logic                busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/asym_dpram_ctl.sv
// Single-clock asymmetric simple dual-port RAM: narrow lane writes, wide reads,
// optional output register, selectable collision policy and a sequenced clear.
module asym_dpram_ctl #(
    parameter int unsigned WR_WIDTH       = 8,
    parameter int unsigned RATIO          = 2,
    parameter int unsigned RD_DEPTH       = 2048,
    parameter int unsigned OUT_REG        = 1,
    parameter int unsigned COLLISION_NEW  = 1,
    parameter int unsigned CLEAR_ON_RESET = 0
) (
    input logic             clk,
    input logic             reset,
    asym_dpram_ctl_if.slave bus
);
    localparam int unsigned RW = WR_WIDTH * RATIO;
    localparam int unsigned RA = $clog2(RD_DEPTH);
    localparam int unsigned LB = $clog2(RATIO);
    localparam int unsigned LW = (LB > 0) ? LB : 1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e        state_q, state_d;
    logic [RA-1:0] cnt_q, cnt_d;
    logic          pend_q;

    logic [RW-1:0] mem [RD_DEPTH];

    logic          wr_acc;
    logic          rd_acc;
    logic [RA-1:0] wr_word;
    logic [LW-1:0] wr_lane;
    logic [RW-1:0] rd_word;

    assign wr_acc  = bus.wr_en && (state_q == StIdle);
    assign rd_acc  = bus.rd_en && (state_q == StIdle);
    assign wr_word = RA'(bus.wr_addr >> LB);
    assign wr_lane = (LB > 0) ? LW'(bus.wr_addr) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.clear_req || pend_q) state_d = StClear;
            end
            StClear: begin
                if (cnt_q == RA'(RD_DEPTH - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // pend_q fires the automatic clear on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= 1'b0;
        end
    end

    // Array is deliberately not reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[wr_word][wr_lane*WR_WIDTH +: WR_WIDTH] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_word = mem[bus.rd_addr];
        if ((COLLISION_NEW != 0) && wr_acc && (wr_word == bus.rd_addr)) begin
            rd_word[wr_lane*WR_WIDTH +: WR_WIDTH] = bus.wr_data;
        end
    end

    logic          v1_q;
    logic [RW-1:0] d1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) d1_q <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic          v2_q;
        logic [RW-1:0] d2_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) d2_q <= d1_q;
            end
        end

        assign bus.rd_valid = v2_q;
        assign bus.rd_data  = d2_q;
    end else begin : g_no_out_reg
        assign bus.rd_valid = v1_q;
        assign bus.rd_data  = d1_q;
    end

    assign bus.busy = (state_q == StClear);
endmodule

// File: tb/tb_asym_dpram_ctl.sv
// Directed bench: two builds side by side on identical stimulus.
// dut_a = OUT_REG 1 / new-data collision, dut_b = OUT_REG 0 / old-data collision.
module tb_asym_dpram_ctl;
    localparam int unsigned WR_WIDTH = 8;
    localparam int unsigned RATIO    = 2;
    localparam int unsigned RD_DEPTH = 2048;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    asym_dpram_ctl_if #(.WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .RD_DEPTH(RD_DEPTH)) bus_a ();
    asym_dpram_ctl_if #(.WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .RD_DEPTH(RD_DEPTH)) bus_b ();

    asym_dpram_ctl #(
        .WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .RD_DEPTH(RD_DEPTH),
        .OUT_REG(1), .COLLISION_NEW(1), .CLEAR_ON_RESET(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    asym_dpram_ctl #(
        .WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .RD_DEPTH(RD_DEPTH),
        .OUT_REG(0), .COLLISION_NEW(0), .CLEAR_ON_RESET(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          busy_a   = 0;
    int          busy_b   = 0;
    logic        blocked  = 1'b0;
    logic        pa_v     = 1'b0;
    logic        pa_care  = 1'b0;
    logic [15:0] pa_d     = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [11:0] wa, input logic [7:0] wd,
                         input logic re, input logic [10:0] ra, input logic cr);
        bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd;
        bus_a.rd_en = re; bus_a.rd_addr = ra; bus_a.clear_req = cr;
        bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd;
        bus_b.rd_en = re; bus_b.rd_addr = ra; bus_b.clear_req = cr;
    endtask

    // One clock of stimulus. dut_b's result for this read is checked right
    // away, dut_a's a cycle later (held in pa_*).
    task automatic step(input string tag, input logic we, input logic [11:0] wa,
                        input logic [7:0] wd, input logic re, input logic [10:0] ra,
                        input logic cr, input logic [15:0] ea, input logic [15:0] eb,
                        input logic care);
        logic v;
        drive(we, wa, wd, re, ra, cr);
        v = re && !blocked;
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        if (bus_a.busy) busy_a++;
        if (bus_b.busy) busy_b++;
        check_eq({tag, "/valid_b"}, 32'(bus_b.rd_valid), 32'(v));
        if (v && care) check_eq({tag, "/data_b"}, 32'(bus_b.rd_data), 32'(eb));
        check_eq({tag, "/valid_a"}, 32'(bus_a.rd_valid), 32'(pa_v));
        if (pa_v && pa_care) check_eq({tag, "/data_a"}, 32'(bus_a.rd_data), 32'(pa_d));
        pa_v    = v;
        pa_d    = ea;
        pa_care = care;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/valid_a", 32'(bus_a.rd_valid), 0);
        check_eq("rst/valid_b", 32'(bus_b.rd_valid), 0);
        check_eq("rst/data_a", 32'(bus_a.rd_data), 0);
        check_eq("rst/data_b", 32'(bus_b.rd_data), 0);
        check_eq("rst/busy_a", 32'(bus_a.busy), 0);
        check_eq("rst/busy_b", 32'(bus_b.busy), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic lane writes then a wide read
        step("wrA", 1, 12'hFFF, 8'h41, 0, '0, 0, '0, '0, 0);
        step("wrB", 1, 12'hFFE, 8'h42, 0, '0, 0, '0, '0, 0);
        step("rd1", 0, '0, '0, 1, 11'h7FF, 0, 16'h4142, 16'h4142, 1);
        idle("idle1");

        // Overwrite then read on the following cycle
        step("wrC", 1, 12'hFFF, 8'h43, 0, '0, 0, '0, '0, 0);
        step("rd2", 0, '0, '0, 1, 11'h7FF, 0, 16'h4342, 16'h4342, 1);
        idle("idle2");

        // Same-cycle collision on lane 0
        step("coll", 1, 12'hFFE, 8'h45, 1, 11'h7FF, 0, 16'h4345, 16'h4342, 1);
        step("coll_rep", 0, '0, '0, 1, 11'h7FF, 0, 16'h4345, 16'h4345, 1);
        idle("idle3");

        // Back-to-back reads of 0x3FF while its lanes are written
        step("half0", 1, 12'h7FF, 8'h5A, 1, 11'h3FF, 0, '0, '0, 0);
        step("half1", 1, 12'h7FE, 8'h59, 1, 11'h3FF, 0, '0, '0, 0);
        step("half2", 1, 12'h7FE, 8'h52, 1, 11'h3FF, 0, 16'h5A52, 16'h5A59, 1);
        step("half3", 0, '0, '0, 1, 11'h3FF, 0, 16'h5A52, 16'h5A52, 1);
        step("half_hi", 0, '0, '0, 1, 11'h7FF, 0, 16'h4345, 16'h4345, 1);
        idle("idle4");

        // Clear request together with an accepted write and read
        step("clr", 1, 12'hFFF, 8'h44, 1, 11'h7FF, 1, 16'h4445, 16'h4345, 1);
        check_eq("clr/busy_start", 32'(bus_a.busy), 1);
        blocked = 1'b1;
        step("blk0", 1, 12'h000, 8'h77, 1, 11'h000, 0, '0, '0, 0);
        step("blk1", 1, 12'h001, 8'h66, 1, 11'h000, 1, '0, '0, 0);
        step("blk2", 1, 12'h000, 8'h55, 1, 11'h001, 0, '0, '0, 0);
        for (int i = 0; i < 3000 && (bus_a.busy || bus_b.busy); i++) begin
            @(posedge clk);
            #1;
            if (bus_a.busy) busy_a++;
            if (bus_b.busy) busy_b++;
        end
        check_eq("clr/busy_cycles_a", busy_a, RD_DEPTH);
        check_eq("clr/busy_cycles_b", busy_b, RD_DEPTH);
        check_eq("clr/busy_end", 32'(bus_a.busy), 0);
        blocked = 1'b0;
        step("post7ff", 0, '0, '0, 1, 11'h7FF, 0, 16'h0000, 16'h0000, 1);
        step("post3ff", 0, '0, '0, 1, 11'h3FF, 0, 16'h0000, 16'h0000, 1);
        step("post000", 0, '0, '0, 1, 11'h000, 0, 16'h0000, 16'h0000, 1);
        idle("idle5");

        // Reset part-way through a clear
        step("wrA2", 1, 12'hFFF, 8'h41, 0, '0, 0, '0, '0, 0);
        step("wrB2", 1, 12'hFFE, 8'h42, 0, '0, 0, '0, '0, 0);
        step("clr2", 0, '0, '0, 0, '0, 1, '0, '0, 0);
        blocked = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid/busy_a", 32'(bus_a.busy), 0);
        check_eq("mid/busy_b", 32'(bus_b.busy), 0);
        check_eq("mid/valid_a", 32'(bus_a.rd_valid), 0);
        check_eq("mid/data_a", 32'(bus_a.rd_data), 0);
        pa_v = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        blocked = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid/no_restart", 32'(bus_a.busy), 0);
        step("mid_rd", 0, '0, '0, 1, 11'h7FF, 0, 16'h4142, 16'h4142, 1);
        idle("idle6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
